redmule_mx_exp_unpacker: RTL and testbench
==========================================

Name: redmule_mx_exp_unpacker

Overview:
- Sits directly downstream of the X-exp / W-exp stream sources (stream IDs 3 and 4), one instance per source.
- Consumes 32-bit words of packed E8M0 shared-scale exponents and unpacks them into a stream of one 8-bit scale per MX block of BLOCK_SIZE elements.
- Feeds the X/W buffer scale inputs with per-job length control.
- Active only when mx_enable is set in the job configuration.

Parameters:
- WORD_W, 32: input exponent word width (MemDw).
- EXP_W, 8: width of one E8M0 scale.
- LANES, WORD_W/EXP_W (=4): scales per input word; derived, must not be overridden.
- CNT_W, 16: width of job scale counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; asynchronous, active-high.
- clear_i  in  1  synchronous soft clear; returns the block to IDLE.
- mx_enable_i  in  1  MX mode enable from the controller.
- start_i  in  1  one-cycle job start pulse.
- num_scales_i  in  CNT_W  total scales for the job; sampled on accepted start_i.
- exp_valid_i  in  1  input word valid from the stream source.
- exp_ready_o  out  1  input word ready.
- exp_data_i  in  WORD_W  packed scales; lane 0 = bits [7:0], emitted first.
- scale_valid_o  out  1  output scale valid.
- scale_ready_i  in  1  output scale ready from the buffer.
- scale_o  out  EXP_W  current scale.
- scale_last_o  out  1  high with the final scale of the job.
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle pulse at job end.

Behaviour:
- Reset values: exp_ready_o=0, scale_valid_o=0, scale_o=0, scale_last_o=0, busy_o=0, done_o=0. Internal state: FSM=IDLE, holding word=0, holding valid=0, lane index=0, remaining=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start_i && mx_enable_i && num_scales_i!=0. remaining<=num_scales_i, lane<=0.
  - IDLE -> DONE on start_i && mx_enable_i && num_scales_i==0 (empty job still pulses done).
  - start_i is ignored when mx_enable_i=0, and outside IDLE.
  - RUN -> DONE on the output handshake with remaining==1.
  - DONE -> IDLE unconditionally after 1 cycle. done_o=1 only in DONE.
- Holding register: one word (word_q), valid bit hv_q, lane_q in 0..LANES-1.
  - exp_ready_o = (state==RUN) && (!hv_q || (pop && lane_q==LANES-1 && remaining>1)).
  - Word accepted on exp_valid_i && exp_ready_o: word_q<=exp_data_i, hv_q<=1, lane_q<=0.
- Output:
  - scale_valid_o = (state==RUN) && hv_q.
  - scale_o = word_q[lane_q*EXP_W +: EXP_W], driven from registers only.
  - scale_last_o = scale_valid_o && remaining==1.
  - While scale_valid_o && !scale_ready_i, scale_o and scale_last_o hold stable.
- Pop (scale_valid_o && scale_ready_i):
  - remaining decrements by 1.
  - If lane_q==LANES-1 or remaining==1: hv_q<=0, unless a new word is accepted in the same cycle.
  - Otherwise lane_q increments by 1.
- Partial last word: when remaining reaches 0 mid-word, the unused upper lanes are discarded. No further word is requested.
- Latency and throughput:
  - A scale is valid 1 cycle after its word is accepted.
  - Steady-state rate is 1 scale/cycle with no bubble at word boundaries: the next word is accepted in the same cycle lane 3 pops.
- clear_i: takes priority over all other events in that cycle. Next state is IDLE with hv_q=0, lane_q=0, remaining=0. done_o is not pulsed.
- Reset or clear mid-job: any partially consumed word is dropped. The upstream streamer is cleared by the controller in the same cycle.
- mx_enable_i dropping during RUN: the job continues. mx_enable_i is only sampled at start.
- busy_o = (state==RUN).

Test Plan:
- num_scales=8, words 0x44332211 then 0x88776655 back-to-back, scale_ready_i tied 1 -> scales 0x11..0x88 on 8 consecutive cycles, no gap at the word boundary. scale_last_o with 0x88, done_o one cycle later, exp_ready_o never high after the 2nd word.
- num_scales=6, words 0xDDCCBBAA, 0x0000FFEE -> output AA,BB,CC,DD,EE,FF. Upper 2 bytes of the 2nd word discarded. Exactly 2 words accepted.
- num_scales=5, scale_ready_i toggled 1,0,0,1,... -> scale_o stable while stalled. Output order matches byte order. Exactly 5 pops.
- start_i with num_scales_i=0 -> done_o pulses the cycle after start, no word accepted, scale_valid_o stays 0. start_i with mx_enable_i=0 -> no state change.
- clear_i asserted after 3 of 8 scales popped -> next cycle IDLE, scale_valid_o=0, exp_ready_o=0, no done_o. A new job of 4 scales then runs correctly from lane 0.
- rst_i asserted asynchronously mid-word -> all outputs 0 immediately, without waiting for a clock edge. After deassert, a new job behaves as in the first scenario.

Source files
------------

// File: rtl/redmule_mx_exp_unpacker.sv
// Unpacks 32-bit words of packed E8M0 shared-scale exponents into a stream of
// one 8-bit scale per MX block, with per-job scale count and done signalling.
module redmule_mx_exp_unpacker #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              mx_enable_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  num_scales_i,
  input  logic              exp_valid_i,
  output logic              exp_ready_o,
  input  logic [WORD_W-1:0] exp_data_i,
  output logic              scale_valid_o,
  input  logic              scale_ready_i,
  output logic [EXP_W-1:0]  scale_o,
  output logic              scale_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned LANES  = WORD_W / EXP_W;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e                       state_q;
  logic [WORD_W-1:0]            word_q;
  logic                         hv_q;
  logic [LANE_W-1:0]            lane_q;
  logic [CNT_W-1:0]             remaining_q;

  logic [LANES-1:0][EXP_W-1:0]  word_lanes;
  logic                         pop;
  logic                         accept;
  logic                         last_lane;
  logic                         last_scale;

  assign word_lanes = word_q;
  assign last_lane  = (lane_q == LANE_W'(LANES - 1));
  assign last_scale = (remaining_q == CNT_W'(1));

  assign scale_valid_o = (state_q == RUN) && hv_q;
  assign scale_o       = word_lanes[lane_q];
  assign scale_last_o  = scale_valid_o && last_scale;
  assign pop           = scale_valid_o && scale_ready_i;

  // Refill in the same cycle the top lane drains so words stream without a bubble.
  assign exp_ready_o = (state_q == RUN) &&
                       (!hv_q || (pop && last_lane && (remaining_q > CNT_W'(1))));
  assign accept      = exp_valid_i && exp_ready_o;

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      word_q      <= '0;
      hv_q        <= 1'b0;
      lane_q      <= '0;
      remaining_q <= '0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      hv_q        <= 1'b0;
      lane_q      <= '0;
      remaining_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && mx_enable_i) begin
            if (num_scales_i != '0) begin
              state_q     <= RUN;
              remaining_q <= num_scales_i;
              lane_q      <= '0;
              hv_q        <= 1'b0;
            end else begin
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          // Any lanes left above the final scale are dropped with the holding word.
          if (pop) begin
            remaining_q <= remaining_q - CNT_W'(1);
            if (last_scale) begin
              state_q <= DONE;
            end
            if (last_lane || last_scale) begin
              hv_q <= 1'b0;
            end else begin
              lane_q <= lane_q + LANE_W'(1);
            end
          end
          if (accept) begin
            word_q <= exp_data_i;
            hv_q   <= 1'b1;
            lane_q <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_redmule_mx_exp_unpacker.sv
// Self-checking bench for redmule_mx_exp_unpacker: directed scenarios plus
// randomized jobs checked against a byte-order reference of the source words.
module tb_redmule_mx_exp_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        mx_enable = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_scales = '0;
  logic        exp_valid = 1'b0;
  logic        exp_ready;
  logic [31:0] exp_data = '0;
  logic        scale_valid;
  logic        scale_ready = 1'b0;
  logic [7:0]  scale_o;
  logic        scale_last;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [31:0] src_words[$];
  logic [7:0]  got[$];
  int n_acc, first_pop, last_pop, done_cyc, extra_req, stall_err, last_err;
  bit timed_out;

  redmule_mx_exp_unpacker dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .clear_i       (clear),
    .mx_enable_i   (mx_enable),
    .start_i       (start),
    .num_scales_i  (num_scales),
    .exp_valid_i   (exp_valid),
    .exp_ready_o   (exp_ready),
    .exp_data_i    (exp_data),
    .scale_valid_o (scale_valid),
    .scale_ready_i (scale_ready),
    .scale_o       (scale_o),
    .scale_last_o  (scale_last),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  // Reference: scale i is byte (i mod 4) of source word (i div 4), lowest byte first.
  function automatic logic [7:0] model_scale(input int i);
    logic [31:0] w;
    w = src_words[i / 4];
    return w[8 * (i % 4) +: 8];
  endfunction

  task automatic start_job(input int num);
    @(negedge clk);
    mx_enable  = 1'b1;
    num_scales = 16'(num);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives words and consumes scales one cycle at a time, observing handshakes mid-cycle.
  task automatic run_stream(input int num, input int ready_mode, input bit valid_rand,
                            input int stop_after);
    int widx;
    bit prev_stall;
    logic [7:0] prev_scale;
    logic prev_last;
    got.delete();
    n_acc = 0; first_pop = -1; last_pop = -1; done_cyc = -1;
    extra_req = 0; stall_err = 0; last_err = 0;
    widx = 0; prev_stall = 0; prev_scale = '0; prev_last = 0;
    for (int k = 0; k < 400; k++) begin
      if (stop_after > 0 && got.size() >= stop_after) break;
      exp_valid = (widx < src_words.size()) && (!valid_rand || $urandom_range(0, 9) < 7);
      exp_data  = (widx < src_words.size()) ? src_words[widx] : $urandom;
      case (ready_mode)
        0:       scale_ready = 1'b1;
        1:       scale_ready = (k % 3 == 0);
        default: scale_ready = ($urandom_range(0, 9) < 6);
      endcase
      #1;
      if (prev_stall && !(scale_valid === 1'b1 && scale_o === prev_scale &&
                          scale_last === prev_last))
        stall_err++;
      if (exp_ready === 1'b1 && n_acc * 4 >= num) extra_req++;
      if (exp_valid && exp_ready === 1'b1) begin
        widx++;
        n_acc++;
      end
      if (scale_valid === 1'b1 && scale_ready) begin
        if (scale_last !== (got.size() == num - 1)) last_err++;
        got.push_back(scale_o);
        if (first_pop < 0) first_pop = k;
        last_pop = k;
      end
      prev_stall = (scale_valid === 1'b1) && !scale_ready;
      prev_scale = scale_o;
      prev_last  = scale_last;
      if (done === 1'b1) begin
        done_cyc = k;
        break;
      end
      @(negedge clk);
    end
    exp_valid   = 1'b0;
    scale_ready = 1'b0;
    timed_out   = (stop_after == 0) && (done_cyc < 0);
  endtask

  task automatic check_job(input string name, input int num);
    checks++;
    if (timed_out) begin
      errors++;
      $display("[TB] FAIL %s timeout: done_o never seen, got %0d scales, need %0d", name, got.size(), num);
    end
    checks++;
    if (got.size() !== num) begin
      errors++;
      $display("[TB] FAIL %s pop_count: got %0d, expected %0d", name, got.size(), num);
    end
    for (int i = 0; i < num && i < got.size(); i++) begin
      checks++;
      if (got[i] !== model_scale(i)) begin
        errors++;
        $display("[TB] FAIL %s scale[%0d]: got %02h, expected %02h", name, i, got[i], model_scale(i));
      end
    end
    checks++;
    if (n_acc !== (num + 3) / 4) begin
      errors++;
      $display("[TB] FAIL %s words_accepted: got %0d, expected %0d", name, n_acc, (num + 3) / 4);
    end
    checks++;
    if (done_cyc !== last_pop + 1) begin
      errors++;
      $display("[TB] FAIL %s done_timing: done at %0d, expected %0d", name, done_cyc, last_pop + 1);
    end
    checks++;
    if (extra_req !== 0) begin
      errors++;
      $display("[TB] FAIL %s extra_ready: %0d cycles, expected 0", name, extra_req);
    end
    checks++;
    if (stall_err !== 0) begin
      errors++;
      $display("[TB] FAIL %s stall_hold: %0d violations, expected 0", name, stall_err);
    end
    checks++;
    if (last_err !== 0) begin
      errors++;
      $display("[TB] FAIL %s scale_last: %0d errors, expected 0", name, last_err);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [12:0] obs;
    obs = {exp_ready, scale_valid, scale_o, scale_last, busy, done};
    checks++;
    if (obs !== 13'h0) begin
      errors++;
      $display("[TB] FAIL %s outputs: got %04h, expected 0000", name, obs);
    end
  endtask

  task automatic test_reset();
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    src_words = '{32'h44332211, 32'h88776655};
    start_job(8);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b busy: got %b, expected 1", busy);
    end
    run_stream(8, 0, 0, 0);
    check_job("b2b", 8);
    checks++;
    if (last_pop - first_pop !== 7) begin
      errors++;
      $display("[TB] FAIL b2b gapless: span %0d, expected 7", last_pop - first_pop);
    end
  endtask

  task automatic test_partial_word();
    src_words = '{32'hDDCCBBAA, 32'h0000FFEE};
    start_job(6);
    run_stream(6, 0, 0, 0);
    check_job("partial", 6);
  endtask

  task automatic test_stall();
    src_words = '{32'h5A4B3C2D, 32'h00000077};
    start_job(5);
    run_stream(5, 1, 0, 0);
    check_job("stall", 5);
  endtask

  task automatic test_empty_and_disabled();
    @(negedge clk);
    mx_enable = 1'b1; num_scales = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if ({done, scale_valid, exp_ready} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL empty_done: got %b, expected 100", {done, scale_valid, exp_ready});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL empty_idle: got %b, expected 00", {done, busy});
    end
    @(negedge clk);
    mx_enable = 1'b0; num_scales = 16'd4; start = 1'b1; exp_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if ({busy, exp_ready, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL disabled_start: got %b, expected 000", {busy, exp_ready, done});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL disabled_hold: got %b, expected 00", {busy, done});
    end
    exp_valid = 1'b0;
    mx_enable = 1'b1;
  endtask

  task automatic test_clear();
    src_words = '{32'h13121110, 32'h17161514};
    start_job(8);
    run_stream(8, 0, 0, 3);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    checks++;
    if ({busy, scale_valid, exp_ready, done} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL clear_idle: got %b, expected 0000", {busy, scale_valid, exp_ready, done});
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_no_done: got %b, expected 0", done);
    end
    src_words = '{32'hA4A3A2A1};
    start_job(4);
    run_stream(4, 0, 0, 0);
    check_job("after_clear", 4);
  endtask

  task automatic test_async_reset();
    src_words = '{32'h44332211, 32'h88776655};
    start_job(8);
    run_stream(8, 0, 0, 2);
    #3;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    test_back_to_back();
  endtask

  task automatic test_random();
    int num;
    for (int j = 0; j < 8; j++) begin
      num = $urandom_range(1, 22);
      src_words.delete();
      for (int w = 0; w < (num + 3) / 4; w++) src_words.push_back($urandom);
      start_job(num);
      if (j % 2 == 1) mx_enable = 1'b0;
      run_stream(num, 2, 1, 0);
      check_job($sformatf("random%0d", j), num);
      mx_enable = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_partial_word();
    test_stall();
    test_empty_and_disabled();
    test_clear();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
